// File: rtl/big_fv_bank_arbiter_pkg.sv
// Shared types for the Big feature-value bank front-end arbiter: controller
// request packet, arbiter state encoding and default sizing.
package big_fv_bank_arbiter_pkg;

  localparam int FV_NUM_EDGE_PE  = 4;
  localparam int FV_MAX_NODE_ID  = 256;
  localparam int FV_NODE_W       = $clog2(FV_MAX_NODE_ID);
  localparam int FV_BANDWIDTH    = 64;
  localparam int FV_PE_TAG_W     = $clog2(FV_NUM_EDGE_PE);
  localparam int FV_STARVE_LIMIT = 8;

  typedef enum logic [2:0] {
    ARB_IDLE = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WB_BURST = 3'd3,
    WB_WAIT  = 3'd4
  } big_fv_arb_state_t;

  // rd_wr: 0 = PE read, 1 = output-buffer write-back beat
  typedef struct packed {
    logic                    valid;
    logic                    rd_wr;
    logic [FV_NODE_W-1:0]    Node_id;
    logic [FV_PE_TAG_W-1:0]  PE_tag;
    logic [FV_BANDWIDTH-1:0] data;
    logic                    wr_eos;
  } Req2Output_SRAM_Bank;

endpackage

// File: rtl/big_fv_bank_arbiter_rr.sv
// NUM_PE-way round-robin picker: first asserted request at or after ptr,
// wrapping; returns one-hot grant, its index and an any-request flag.
module rr_arbiter #(
  parameter int NUM_PE = 4,
  parameter int IDX_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic [NUM_PE-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_PE-1:0] grant,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req;
    // Scan from the farthest offset back so the nearest request wins last.
    for (int k = NUM_PE - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NUM_PE) j = j - NUM_PE;
      if (req[IDX_W'(j)]) idx = IDX_W'(j);
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/big_fv_bank_arbiter.sv
// Shares one bank-controller request port between NUM_PE Edge PE readers and
// one write-back source; holds each grant until the controller is idle again.
module big_fv_bank_arbiter
  import big_fv_bank_arbiter_pkg::*;
#(
  parameter int NUM_PE       = FV_NUM_EDGE_PE,
  parameter int NODE_W       = FV_NODE_W,
  parameter int STARVE_LIMIT = FV_STARVE_LIMIT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          bank_available,
  input  logic                          stream_mode,
  input  logic [NUM_PE-1:0]             pe_rd_req,
  input  logic [NUM_PE-1:0][NODE_W-1:0] pe_rd_node_id,
  output logic [NUM_PE-1:0]             pe_rd_ack,
  input  logic                          wb_req,
  input  logic [NODE_W-1:0]             wb_node_id,
  input  logic [FV_BANDWIDTH-1:0]       wb_data,
  input  logic                          wb_eos,
  output logic                          wb_ready,
  output Req2Output_SRAM_Bank           req_pkt,
  output logic                          busy,
  output logic                          protocol_err,
  output big_fv_arb_state_t             dbg_state_o
);

  localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  big_fv_arb_state_t   state_q, state_d;
  Req2Output_SRAM_Bank pkt_q, pkt_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic                perr_q, perr_d;

  logic [NUM_PE-1:0]   rd_grant;
  logic [IDX_W-1:0]    rd_idx;
  logic                rd_any;
  logic                grant_ok;
  logic                wb_win;

  rr_arbiter #(
    .NUM_PE (NUM_PE),
    .IDX_W  (IDX_W)
  ) u_rr (
    .req   (pe_rd_req),
    .ptr   (rr_ptr_q),
    .grant (rd_grant),
    .idx   (rd_idx),
    .any   (rd_any)
  );

  // Handshakes: a PE read is taken in the cycle pe_rd_ack[i] pulses (request
  // held until then); a write-back beat is taken when wb_req && wb_ready.
  // Reset gates the grant so no ack/ready escapes while reset is asserted.
  assign grant_ok = reset && bank_available && !stream_mode;
  // Write-back loses only to a pending read once it has hit the starve limit.
  assign wb_win   = wb_req && ((starve_q < STARVE_MAX) || !rd_any);

  always_comb begin
    state_d   = state_q;
    pkt_d     = '0;
    rr_ptr_d  = rr_ptr_q;
    starve_d  = starve_q;
    perr_d    = perr_q;
    pe_rd_ack = '0;
    wb_ready  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (grant_ok && wb_win) begin
          wb_ready      = 1'b1;
          pkt_d.valid   = 1'b1;
          pkt_d.rd_wr   = 1'b1;
          pkt_d.Node_id = FV_NODE_W'(wb_node_id);
          pkt_d.data    = wb_data;
          pkt_d.wr_eos  = wb_eos;
          if (rd_any && (starve_q < STARVE_MAX)) starve_d = starve_q + 1'b1;
          state_d = wb_eos ? WB_WAIT : WB_BURST;
        end else if (grant_ok && rd_any) begin
          pe_rd_ack     = rd_grant;
          pkt_d.valid   = 1'b1;
          pkt_d.Node_id = FV_NODE_W'(pe_rd_node_id[rd_idx]);
          pkt_d.PE_tag  = FV_PE_TAG_W'(rd_idx);
          rr_ptr_d      = (rd_idx == IDX_W'(NUM_PE - 1)) ? '0 : rd_idx + 1'b1;
          starve_d      = '0;
          state_d       = RD_ISSUE;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT, WB_WAIT: begin
        if (bank_available) state_d = ARB_IDLE;
      end
      WB_BURST: begin
        wb_ready = 1'b1;
        if (wb_req) begin
          pkt_d.valid   = 1'b1;
          pkt_d.rd_wr   = 1'b1;
          pkt_d.Node_id = FV_NODE_W'(wb_node_id);
          pkt_d.data    = wb_data;
          pkt_d.wr_eos  = wb_eos;
          if (wb_eos) state_d = WB_WAIT;
        end else begin
          // Source gapped: keep the last beat's fields, drop valid, flag it.
          pkt_d       = pkt_q;
          pkt_d.valid = 1'b0;
          perr_d      = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_IDLE;
      pkt_q    <= '0;
      rr_ptr_q <= '0;
      starve_q <= '0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pkt_q    <= pkt_d;
      rr_ptr_q <= rr_ptr_d;
      starve_q <= starve_d;
      perr_q   <= perr_d;
    end
  end

  assign req_pkt      = pkt_q;
  assign busy         = (state_q != ARB_IDLE);
  assign protocol_err = perr_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_big_fv_bank_arbiter.sv
// Directed bench for big_fv_bank_arbiter: inputs change on the falling edge,
// outputs are checked 1 time unit later, expected values are hand-computed.
`define CHK(tag, obs, exp) check(tag, 128'(obs), 128'(exp))

module tb_big_fv_bank_arbiter;
  import big_fv_bank_arbiter_pkg::*;

  logic                clk;
  logic                reset;
  logic                bank_available;
  logic                stream_mode;
  logic [3:0]          pe_rd_req;
  logic [3:0][7:0]     pe_rd_node_id;
  logic [3:0]          pe_rd_ack;
  logic                wb_req;
  logic [7:0]          wb_node_id;
  logic [63:0]         wb_data;
  logic                wb_eos;
  logic                wb_ready;
  Req2Output_SRAM_Bank req_pkt;
  logic                busy;
  logic                protocol_err;
  big_fv_arb_state_t   dbg_state;

  int tests = 0;
  int fails = 0;
  logic [1:0] exp_q[$];
  logic [1:0] e;
  logic [3:0] onehot;

  big_fv_bank_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .bank_available (bank_available),
    .stream_mode    (stream_mode),
    .pe_rd_req      (pe_rd_req),
    .pe_rd_node_id  (pe_rd_node_id),
    .pe_rd_ack      (pe_rd_ack),
    .wb_req         (wb_req),
    .wb_node_id     (wb_node_id),
    .wb_data        (wb_data),
    .wb_eos         (wb_eos),
    .wb_ready       (wb_ready),
    .req_pkt        (req_pkt),
    .busy           (busy),
    .protocol_err   (protocol_err),
    .dbg_state_o    (dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; bank_available = 1'b0; stream_mode = 1'b0;
    pe_rd_req = '0; pe_rd_node_id = '0;
    wb_req = 1'b0; wb_node_id = '0; wb_data = '0; wb_eos = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    `CHK("rst_pkt", req_pkt, 0);
    `CHK("rst_ack", pe_rd_ack, 0);
    `CHK("rst_ready", wb_ready, 0);
    `CHK("rst_busy", busy, 0);
    `CHK("rst_perr", protocol_err, 0);

    // Reset asserted in the middle of a write-back burst
    @(negedge clk); reset = 1'b1;
    @(negedge clk); bank_available = 1'b1; wb_req = 1'b1; wb_node_id = 8'h21;
    wb_data = 64'hA0; wb_eos = 1'b0; #1;
    `CHK("midrst_ready_t", wb_ready, 1);
    @(negedge clk); wb_data = 64'hA1; #1;
    `CHK("midrst_valid", req_pkt.valid, 1);
    `CHK("midrst_data", req_pkt.data, 64'hA0);
    `CHK("midrst_busy", busy, 1);
    reset = 1'b0; #1;
    `CHK("midrst_pkt0", req_pkt, 0);
    `CHK("midrst_ready0", wb_ready, 0);
    `CHK("midrst_busy0", busy, 0);
    `CHK("midrst_ack0", pe_rd_ack, 0);
    @(negedge clk); wb_req = 1'b0; wb_data = '0; reset = 1'b1;
    @(negedge clk); #1;
    `CHK("midrst_nopkt", req_pkt.valid, 0);
    `CHK("midrst_idle", busy, 0);

    // Single read from PE2
    @(negedge clk); pe_rd_req = 4'b0100; pe_rd_node_id[2] = 8'h13; #1;
    `CHK("pe2_ack", pe_rd_ack, 4'b0100);
    @(negedge clk); pe_rd_req = '0; #1;
    `CHK("pe2_valid", req_pkt.valid, 1);
    `CHK("pe2_rdwr", req_pkt.rd_wr, 0);
    `CHK("pe2_node", req_pkt.Node_id, 8'h13);
    `CHK("pe2_tag", req_pkt.PE_tag, 2);
    `CHK("pe2_ack_gone", pe_rd_ack, 0);
    `CHK("pe2_state", dbg_state, RD_ISSUE);
    @(negedge clk); bank_available = 1'b0; #1;
    `CHK("pe2_valid_t2", req_pkt.valid, 0);
    `CHK("pe2_busy_t2", busy, 1);
    @(negedge clk); bank_available = 1'b1; #1;
    `CHK("pe2_wait", dbg_state, RD_WAIT);
    @(negedge clk); #1;
    `CHK("pe2_back_idle", busy, 0);

    // Reset pulse so the round-robin pointer starts at 0
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;

    // All PEs requesting, bank busy 3 cycles per read
    for (int i = 0; i < 4; i++) pe_rd_node_id[i] = 8'h30 + 8'(i);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    for (int g = 0; g < 5; g++) begin
      e = exp_q.pop_front();
      onehot = 4'b0001 << e;
      @(negedge clk); pe_rd_req = 4'hF; bank_available = 1'b1; #1;
      tests++;
      if (pe_rd_ack !== onehot) begin
        fails++;
        $error("FAIL rr_ack: observed %0h expected %0h", pe_rd_ack, onehot);
      end
      @(negedge clk); #1;
      `CHK("rr_valid", req_pkt.valid, 1);
      tests++;
      if (req_pkt.PE_tag !== e) begin
        fails++;
        $error("FAIL rr_tag: observed %0h expected %0h", req_pkt.PE_tag, e);
      end
      `CHK("rr_node", req_pkt.Node_id, 8'h30 + 8'(e));
      repeat (3) begin
        @(negedge clk); bank_available = 1'b0; #1;
        `CHK("rr_hold_ack", pe_rd_ack, 0);
      end
      @(negedge clk); bank_available = 1'b1; #1;
      `CHK("rr_wait", dbg_state, RD_WAIT);
    end

    // 4-beat write-back burst
    @(negedge clk); pe_rd_req = '0; wb_req = 1'b1; wb_node_id = 8'h55;
    wb_data = 64'hD0; wb_eos = 1'b0; #1;
    `CHK("wb4_ready0", wb_ready, 1);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); wb_data = 64'hD0 + 64'(k); wb_eos = (k == 3); #1;
      `CHK("wb4_ready", wb_ready, 1);
      `CHK("wb4_valid", req_pkt.valid, 1);
      tests++;
      if (req_pkt.data !== 64'hD0 + 64'(k - 1)) begin
        fails++;
        $error("FAIL wb4_data: observed %0h expected %0h", req_pkt.data, 64'hD0 + 64'(k - 1));
      end
      `CHK("wb4_eos_lo", req_pkt.wr_eos, 0);
    end
    @(negedge clk); wb_req = 1'b0; wb_eos = 1'b0; #1;
    `CHK("wb4_ready_off", wb_ready, 0);
    `CHK("wb4_last_valid", req_pkt.valid, 1);
    `CHK("wb4_last_data", req_pkt.data, 64'hD3);
    `CHK("wb4_last_eos", req_pkt.wr_eos, 1);
    `CHK("wb4_node", req_pkt.Node_id, 8'h55);
    `CHK("wb4_state", dbg_state, WB_WAIT);
    @(negedge clk); #1;
    `CHK("wb4_cleared", req_pkt.valid, 0);
    `CHK("wb4_idle", busy, 0);

    // Write-back starving PE1 up to the limit
    @(negedge clk); pe_rd_req = 4'b0010; pe_rd_node_id[1] = 8'h71;
    wb_req = 1'b1; wb_eos = 1'b1; wb_node_id = 8'h66; wb_data = 64'hF0;
    for (int g = 0; g < 8; g++) begin
      #1;
      `CHK("starve_ready", wb_ready, 1);
      `CHK("starve_no_ack", pe_rd_ack, 0);
      @(negedge clk); #1;
      `CHK("starve_wait_ready", wb_ready, 0);
      `CHK("starve_pkt_wr", req_pkt.rd_wr, 1);
      `CHK("starve_pkt_eos", req_pkt.wr_eos, 1);
      @(negedge clk);
    end
    #1;
    `CHK("starve_pe1_ack", pe_rd_ack, 4'b0010);
    `CHK("starve_pe1_noready", wb_ready, 0);
    @(negedge clk); pe_rd_req = '0; #1;
    `CHK("starve_pe1_tag", req_pkt.PE_tag, 1);
    `CHK("starve_pe1_node", req_pkt.Node_id, 8'h71);
    @(negedge clk); #1;
    `CHK("starve_rd_wait", dbg_state, RD_WAIT);
    @(negedge clk); pe_rd_req = 4'b0010; #1;
    `CHK("starve_cnt_clr_ready", wb_ready, 1);
    `CHK("starve_cnt_clr_ack", pe_rd_ack, 0);
    @(negedge clk); wb_req = 1'b0; pe_rd_req = '0; #1;
    `CHK("starve_wb_wait", dbg_state, WB_WAIT);
    @(negedge clk); #1;
    `CHK("starve_idle", busy, 0);

    // Replay-stream phase blocks all grants
    @(negedge clk); stream_mode = 1'b1; pe_rd_req = 4'b0001; pe_rd_node_id[0] = 8'h5A;
    wb_req = 1'b1; wb_eos = 1'b1; wb_node_id = 8'h77;
    repeat (3) begin
      #1;
      `CHK("stream_ready", wb_ready, 0);
      `CHK("stream_ack", pe_rd_ack, 0);
      `CHK("stream_busy", busy, 0);
      @(negedge clk);
    end
    stream_mode = 1'b0; #1;
    `CHK("stream_drop_ready", wb_ready, 1);
    `CHK("stream_drop_ack", pe_rd_ack, 0);
    @(negedge clk); wb_req = 1'b0; wb_eos = 1'b0; #1;
    `CHK("stream_wb_valid", req_pkt.valid, 1);
    `CHK("stream_wb_node", req_pkt.Node_id, 8'h77);
    @(negedge clk); #1;
    `CHK("stream_rd_ack", pe_rd_ack, 4'b0001);
    @(negedge clk); pe_rd_req = '0; #1;
    `CHK("stream_rd_node", req_pkt.Node_id, 8'h5A);
    `CHK("stream_rd_tag", req_pkt.PE_tag, 0);
    @(negedge clk);
    @(negedge clk);

    // Write-back gap sets the sticky protocol error
    wb_req = 1'b1; wb_node_id = 8'h44; wb_data = 64'hE0; wb_eos = 1'b0; #1;
    `CHK("gap_ready0", wb_ready, 1);
    @(negedge clk); wb_req = 1'b0; #1;
    `CHK("gap_beat0_valid", req_pkt.valid, 1);
    `CHK("gap_beat0_data", req_pkt.data, 64'hE0);
    `CHK("gap_perr_before", protocol_err, 0);
    `CHK("gap_ready_in_gap", wb_ready, 1);
    @(negedge clk); wb_req = 1'b1; wb_data = 64'hE1; wb_eos = 1'b1; #1;
    `CHK("gap_valid0", req_pkt.valid, 0);
    `CHK("gap_held_data", req_pkt.data, 64'hE0);
    `CHK("gap_held_node", req_pkt.Node_id, 8'h44);
    `CHK("gap_perr", protocol_err, 1);
    @(negedge clk); wb_req = 1'b0; wb_eos = 1'b0; #1;
    `CHK("gap_last_valid", req_pkt.valid, 1);
    `CHK("gap_last_data", req_pkt.data, 64'hE1);
    `CHK("gap_last_eos", req_pkt.wr_eos, 1);
    `CHK("gap_perr_sticky", protocol_err, 1);
    @(negedge clk); #1;
    `CHK("gap_perr_idle", protocol_err, 1);
    `CHK("gap_idle", busy, 0);
    reset = 1'b0; #1;
    `CHK("gap_perr_reset", protocol_err, 0);
    @(negedge clk); reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/big_fv_bank_arbiter.md
# big_fv_bank_arbiter

Front-end arbiter for one Big feature-value bank controller. It shares the controller's single request port between `NUM_PE` Edge PE read requesters and one output-buffer write-back source (acc_buff/vertex_buff). It issues registered request packets only when the controller is idle and not in a replay-stream phase. Each grant is held until the controller returns to idle.

## Interface
Parameters:
- `NUM_PE`, `` `Num_Edge_PE `` (4): number of Edge PE read requesters.
- `NODE_W`, `` $clog2(`Max_Node_id) ``: node id width.
- `STARVE_LIMIT`, 8: maximum number of consecutive write-back grants while any read is pending.

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-low.
- `bank_available`, in, 1: controller idle flag.
- `stream_mode`, in, 1: current update iteration is in replay-stream phase; no grants while high.
- `pe_rd_req`, in, `NUM_PE`: per-PE read request, held until acked.
- `pe_rd_node_id`, in, `NUM_PE`×`NODE_W`: per-PE node id.
- `pe_rd_ack`, out, `NUM_PE`: one-hot, 1-cycle grant pulse.
- `wb_req`, in, 1: write-back beat valid.
- `wb_node_id`, in, `NODE_W`: write-back node id; constant for the whole burst.
- `wb_data`, in, `` `FV_bandwidth ``: write-back beat data.
- `wb_eos`, in, 1: last beat of the burst.
- `wb_ready`, out, 1: beat accepted when `wb_req && wb_ready`.
- `req_pkt`, out, `Req2Output_SRAM_Bank`: registered packet to the controller.
- `busy`, out, 1: arbiter state is not ARB_IDLE.
- `protocol_err`, out, 1: sticky; set on a write-back gap.

## Operation
States: ARB_IDLE, RD_ISSUE, RD_WAIT, WB_BURST, WB_WAIT.

ARB_IDLE:
- A grant is legal only when `bank_available && !stream_mode`.
- Write-back wins if `wb_req` is high and the starve counter is below `STARVE_LIMIT`. Otherwise the round-robin read winner wins.
- A read winner is the first asserted `pe_rd_req` at or after `rr_ptr`, wrapping modulo `NUM_PE`.

Read grant:
- `pe_rd_ack[i]` pulses in the decision cycle.
- The packet is registered: valid=1, rd_wr=0, Node_id=`pe_rd_node_id[i]`, PE_tag=i.
- `rr_ptr` ← i+1, wrapping.
- Starve counter ← 0.
- Next state RD_ISSUE.

Write grant:
- `wb_ready`=1 in the decision cycle and beat 0 is accepted.
- The packet is registered: valid=1, rd_wr=1, Node_id, data, wr_eos.
- Starve counter increments, saturating, only if any `pe_rd_req` is high.
- Next state is WB_WAIT if `wb_eos`, else WB_BURST.

RD_ISSUE:
- Packet valid is visible for exactly this one cycle.
- Next state RD_WAIT; the packet is cleared to valid=0.

RD_WAIT:
- Return to ARB_IDLE on the first cycle where `bank_available`=1.

WB_BURST:
- `wb_ready`=1 every cycle and each accepted beat is registered.
- On an accepted `wb_eos` beat, go to WB_WAIT.
- If `wb_req`=0 (gap): valid=0, Node_id and data are held, and `protocol_err` is set.

WB_WAIT:
- `wb_ready`=0 and the packet is cleared.
- Return to ARB_IDLE on the first cycle where `bank_available`=1.

Other rules:
- `pe_rd_ack` and `wb_ready` are 0 in every state not listed above.
- `stream_mode` is honoured only in ARB_IDLE; an in-flight grant always completes.
- `pe_rd_node_id`/`wb_node_id` are sampled only in the accept cycle.

## Timing
- Decision cycle t → packet valid at cycle t+1. The controller samples it while idle, and `bank_available` is low from t+2.
- Minimum read-to-read spacing: decision, issue, ≥1 wait cycle.
- Write-back beats are back-to-back: beat k is accepted at t+k and presented at t+k+1.
- Write-back sources must not gap.
- If `bank_available` and the requests are already high at a grant, the next grant is made only after WB_WAIT/RD_WAIT observes available.

Reset (asserted):
- State ARB_IDLE.
- `req_pkt`=0, `pe_rd_ack`=0, `wb_ready`=0, `busy`=0, `protocol_err`=0.
- `rr_ptr`=0, starve counter=0.
- Reset mid-burst drops the burst with no further packets issued.

## Structure
- Shared package: `Req2Output_SRAM_Bank` (already defined), the arbiter state enum `big_fv_arb_state_t`, and `STARVE_LIMIT` default.
- One sub-module: `rr_arbiter` (`NUM_PE`-way round-robin, inputs req/ptr, output one-hot grant and index).

## Test plan
- Reset low mid-operation → all outputs 0 within the same cycle; after release, PE2 req node 0x13 → `pe_rd_ack`=0100 at t, `req_pkt` valid with Node_id 0x13, PE_tag 2 at t+1 only.
- PEs 0..3 requesting continuously with `bank_available` toggling 3 cycles low per read → grant order 0,1,2,3,0.
- 4-beat write-back (eos on beat 3) → `wb_ready` high 4 consecutive cycles, packets valid t+1..t+4, wr_eos only on t+4.
- `wb_req` continuous single-beat and PE1 pending, `STARVE_LIMIT`=8 → 8 write grants then PE1 granted, counter back to 0.
- `stream_mode`=1 with requests pending → no ack/ready; drop `stream_mode` → grant next cycle with `bank_available`=1.
- Gap: `wb_req` low for 1 cycle in WB_BURST → valid=0 that cycle, held data, `protocol_err`=1 until reset.
